// File: rtl/uart_pkg.sv
// Shared UART definitions: autobaud FSM encoding, sync character and measurement constants.
package uart_pkg;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_START = 2'd1;
  localparam logic [1:0] ST_MEASURE    = 2'd2;

  localparam logic [7:0] SYNC_CHAR = 8'h55;
  localparam int unsigned ROUND_ADD = 4;

  // Line transitions from the start-bit fall up to the fall that opens the last data bit.
  function automatic int unsigned count_edges(input logic [7:0] ch);
    logic [9:0]  frame;
    int unsigned n;
    frame = {1'b1, ch, 1'b0};
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (frame[i] != frame[i+1]) n++;
    end
    return n;
  endfunction

  localparam int unsigned SYNC_EDGES = count_edges(SYNC_CHAR);

endpackage

// File: rtl/uart_sync_edge_det.sv
// Two-flop synchronizer for an idle-high UART line followed by registered fall/rise pulses.
module uart_sync_edge_det (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic rx_i,
  output logic fall_o,
  output logic rise_o
);

  logic sync1_q, sync2_q, prev_q, fall_q, rise_q;
  logic fall_d, rise_d;

  always_comb begin
    fall_d = prev_q & ~sync2_q;
    rise_d = ~prev_q & sync2_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      fall_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fall_q  <= fall_d;
      rise_q  <= rise_d;
    end
  end

  assign fall_o = fall_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/uart_autobaud_det.sv
// UART autobaud detector: times eight bit periods of a 0x55 sync character and emits a divisor.
// Optional segment tolerance checking is enabled with macro UART_AUTOBAUD_TOL_CHK_EN.
module uart_autobaud_det
  import uart_pkg::*;
#(
  parameter int unsigned DLY            = 1,
  parameter int unsigned BAUDRATE_WIDTH = 16,
  parameter int unsigned MIN_CFG        = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      rx_i,
  input  logic                      start_i,
  output logic [BAUDRATE_WIDTH-1:0] baudrate_cfg_o,
  output logic                      cfg_vld_o,
  output logic                      err_o,
  output logic                      busy_o
);

  localparam int unsigned TW    = BAUDRATE_WIDTH + 3;
  localparam int unsigned SHIFT = $clog2(SYNC_EDGES);
  localparam int unsigned ECW   = $clog2(SYNC_EDGES) + 1;

  // DLY only shaped simulation timing in the legacy flow; registers here update with zero delay.
  if (DLY > 1000) begin : g_dly_chk
    $error("DLY out of range");
  end

  logic [1:0]                state_q, state_d;
  logic [TW-1:0]             total_q, total_d;
  logic [ECW-1:0]            edge_cnt_q, edge_cnt_d;
  logic [BAUDRATE_WIDTH-1:0] cfg_q, cfg_d;
  logic                      vld_q, vld_d, err_q, err_d;
  logic                      fall, rise, edge_det, term, tol_err;
  logic [TW:0]               span, rounded;
  logic [BAUDRATE_WIDTH-1:0] cfg_new;

  uart_sync_edge_det u_sync_edge_det (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .rx_i   (rx_i),
    .fall_o (fall),
    .rise_o (rise)
  );

  assign edge_det = fall | rise;
  assign term     = edge_det && (edge_cnt_q == ECW'(SYNC_EDGES - 1));
  // Span includes the terminating cycle, so it equals the edge-to-edge distance.
  assign span     = {1'b0, total_q} + (TW+1)'(1);
  assign rounded  = (span + (TW+1)'(ROUND_ADD)) >> SHIFT;
  assign cfg_new  = BAUDRATE_WIDTH'(rounded - (TW+1)'(1));

`ifdef UART_AUTOBAUD_TOL_CHK_EN
  logic [TW-1:0] seg_q, seg_d;
  logic [TW:0]   w0_q, w0_d, seg_w, lo, hi;
  logic          w0_vld_q, w0_vld_d;

  assign seg_w = {1'b0, seg_q} + (TW+1)'(1);
  assign lo    = w0_q - (w0_q >> 2);
  assign hi    = w0_q + (w0_q >> 2);

  always_comb begin
    seg_d    = seg_q + TW'(1);
    w0_d     = w0_q;
    w0_vld_d = w0_vld_q;
    tol_err  = 1'b0;
    if ((state_q != ST_MEASURE) || start_i) begin
      seg_d    = '0;
      w0_vld_d = 1'b0;
    end else if (edge_det) begin
      seg_d = '0;
      if (!w0_vld_q) begin
        w0_d     = seg_w;
        w0_vld_d = 1'b1;
      end else begin
        tol_err = (seg_w < lo) || (seg_w > hi);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      seg_q    <= '0;
      w0_q     <= '0;
      w0_vld_q <= 1'b0;
    end else begin
      seg_q    <= seg_d;
      w0_q     <= w0_d;
      w0_vld_q <= w0_vld_d;
    end
  end
`else
  assign tol_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    edge_cnt_d = edge_cnt_q;
    cfg_d      = cfg_q;
    vld_d      = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_WAIT_START;
          total_d    = '0;
          edge_cnt_d = '0;
        end
      end
      ST_WAIT_START: begin
        if (start_i || fall) begin
          state_d    = start_i ? ST_WAIT_START : ST_MEASURE;
          total_d    = '0;
          edge_cnt_d = '0;
        end
      end
      ST_MEASURE: begin
        if (start_i) begin
          state_d    = ST_WAIT_START;
          total_d    = '0;
          edge_cnt_d = '0;
        end else if (tol_err) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (term) begin
          state_d = ST_IDLE;
          if (cfg_new >= BAUDRATE_WIDTH'(MIN_CFG)) begin
            cfg_d = cfg_new;
            vld_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (total_q == '1) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          total_d = total_q + TW'(1);
          if (edge_det) edge_cnt_d = edge_cnt_q + ECW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      total_q    <= '0;
      edge_cnt_q <= '0;
      cfg_q      <= '0;
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      edge_cnt_q <= edge_cnt_d;
      cfg_q      <= cfg_d;
      vld_q      <= vld_d;
      err_q      <= err_d;
    end
  end

  assign baudrate_cfg_o = cfg_q;
  assign cfg_vld_o      = vld_q;
  assign err_o          = err_q;
  assign busy_o         = (state_q == ST_WAIT_START) || (state_q == ST_MEASURE);

endmodule

// File: tb/tb_uart_autobaud_det.sv
// Bench for uart_autobaud_det: directed and random 0x55 frames against an arithmetic model.
module tb_uart_autobaud_det;

  localparam int unsigned BW   = 12;
  localparam int unsigned MINC = 3;
  localparam int          TMAX = (1 << (BW + 3)) - 1;

  logic          clk_i   = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          rx_i    = 1'b1;
  logic          start_i = 1'b0;
  logic [BW-1:0] baudrate_cfg_o;
  logic          cfg_vld_o, err_o, busy_o;

  int tests = 0, fails = 0;
  int cyc = 0, vld_cnt = 0, err_cnt = 0, last_vld_cyc = -1, last_err_cyc = -1;
  int seg[8];
  int model_cfg = 0;
  int term_cyc = 0;

  uart_autobaud_det #(
    .DLY           (1),
    .BAUDRATE_WIDTH(BW),
    .MIN_CFG       (MINC)
  ) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .rx_i          (rx_i),
    .start_i       (start_i),
    .baudrate_cfg_o(baudrate_cfg_o),
    .cfg_vld_o     (cfg_vld_o),
    .err_o         (err_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    cyc++;
    if (cfg_vld_o === 1'b1) begin vld_cnt++; last_vld_cyc = cyc; end
    if (err_o === 1'b1) begin err_cnt++; last_err_cyc = cyc; end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_i);
      #1;
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
  endtask

  // Drives start bit and b0..b6 from seg[], then b7 low for 'tail' cycles and the stop bit.
  task automatic drive_frame(input int tail);
    for (int i = 0; i < 8; i++) begin
      rx_i = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(seg[i]);
    end
    term_cyc = cyc;
    rx_i = 1'b0;
    step(tail);
    rx_i = 1'b1;
    step(tail + 20);
  endtask

  task automatic run_frame(input string tag);
    int  total, cfg, v0, e0, w0;
    bit  tol_bad, exp_vld;
    total = 0;
    foreach (seg[i]) total += seg[i];
    cfg = (((total + 4) >> 3) - 1) & ((1 << BW) - 1);
    tol_bad = 1'b0;
`ifdef UART_AUTOBAUD_TOL_CHK_EN
    w0 = seg[0];
    for (int i = 1; i < 8; i++)
      if (seg[i] < w0 - (w0 >> 2) || seg[i] > w0 + (w0 >> 2)) tol_bad = 1'b1;
`else
    w0 = 0;
`endif
    exp_vld = !tol_bad && (cfg >= MINC);
    if (exp_vld) model_cfg = cfg;
    v0 = vld_cnt;
    e0 = err_cnt;
    pulse_start();
    step(3);
    check({tag, " busy armed"}, busy_o, 1);
    drive_frame(seg[0] + w0 * 0);
    check({tag, " vld pulses"}, vld_cnt - v0, exp_vld ? 1 : 0);
    check({tag, " err pulses"}, err_cnt - e0, exp_vld ? 0 : 1);
    check({tag, " cfg"}, baudrate_cfg_o, model_cfg);
    check({tag, " busy after"}, busy_o, 0);
    if (exp_vld)
      check({tag, " vld latency"}, (last_vld_cyc - term_cyc >= 1) && (last_vld_cyc - term_cyc <= 8), 1);
  endtask

  initial begin
    int v0, e0, t0, per;

    step(2);
    check("rst cfg", baudrate_cfg_o, 0);
    check("rst vld", cfg_vld_o, 0);
    check("rst err", err_o, 0);
    check("rst busy", busy_o, 0);
    rst_n_i = 1'b1;
    step(5);

    foreach (seg[i]) seg[i] = 16;
    run_frame("t16");
    check("t16 total cfg", baudrate_cfg_o, 15);

    seg = '{101, 100, 101, 100, 101, 100, 100, 100};
    run_frame("t100");
    check("t100 cfg", baudrate_cfg_o, 99);

    foreach (seg[i]) seg[i] = 2;
    run_frame("t2");
    check("t2 keeps cfg", baudrate_cfg_o, 99);

    seg = '{16, 24, 16, 16, 16, 16, 16, 16};
    run_frame("tol");

    // Start bit then line stuck low: counter must run out.
    v0 = vld_cnt;
    e0 = err_cnt;
    pulse_start();
    step(3);
    rx_i = 1'b0;
    t0 = cyc;
    step(TMAX + 40);
    check("tmo err pulses", err_cnt - e0, 1);
    check("tmo vld pulses", vld_cnt - v0, 0);
    check("tmo err time", (last_err_cyc - t0 > TMAX) && (last_err_cyc - t0 <= TMAX + 10), 1);
    check("tmo busy", busy_o, 0);
    check("tmo cfg kept", baudrate_cfg_o, model_cfg);
    rx_i = 1'b1;
    step(10);

    for (int k = 0; k < 6; k++) begin
      per = $urandom_range(120, 3);
      foreach (seg[i]) seg[i] = per + $urandom_range(per / 4, 0) - per / 8;
      run_frame($sformatf("rnd%0d", k));
    end

    // Reset after the third edge abandons the measurement.
    foreach (seg[i]) seg[i] = 16;
    v0 = vld_cnt;
    e0 = err_cnt;
    pulse_start();
    step(3);
    for (int i = 0; i < 3; i++) begin
      rx_i = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(seg[i]);
    end
    rst_n_i = 1'b0;
    step(1);
    model_cfg = 0;
    check("mid rst cfg", baudrate_cfg_o, 0);
    check("mid rst vld", cfg_vld_o, 0);
    check("mid rst err", err_o, 0);
    check("mid rst busy", busy_o, 0);
    rst_n_i = 1'b1;
    for (int i = 3; i < 8; i++) begin
      rx_i = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(seg[i]);
    end
    rx_i = 1'b0;
    step(16);
    rx_i = 1'b1;
    step(40);
    check("post rst vld", vld_cnt - v0, 0);
    check("post rst err", err_cnt - e0, 0);
    check("post rst busy", busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
